// File: rtl/mac_arb_pkg.sv
// Shared types and helpers for the MAC TX round-robin arbiter.
package mac_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   // Index width for a given port count; never returns less than 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return (result == 0) ? 32'd1 : result;
   endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// Rotating-priority encoder: first request strictly after ptr wins, wrapping at NUM_PORTS.
module rr_arbiter #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned PTR_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] win,
   output logic [PTR_W-1:0]     win_idx
);

   logic             w_found;
   logic [PTR_W-1:0] w_cand;

   always_comb begin
      win_idx = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         w_cand = PTR_W'((32'(ptr) + i) % NUM_PORTS);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            win_idx = w_cand;
         end
      end
   end

   assign win = w_found ? (NUM_PORTS'(1) << win_idx) : '0;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding the single MAC TX AXI-Stream input.
// Optional per-port completed-frame counters are built when ARB_STATS_EN is defined.
module mac_tx_arbiter
   import mac_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDLE_GAP   = 1,
   parameter int unsigned STAT_WIDTH = 32
) (
   input  logic                                sys_clk,
   input  logic                                sys_rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                s_axis_tlast,
   output logic [NUM_PORTS-1:0]                s_axis_tready,
   output logic [DATA_WIDTH-1:0]               m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]             m_axis_tkeep,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   input  logic [NUM_PORTS-1:0]                port_enable,
   output logic [NUM_PORTS-1:0]                grant,
   output logic                                busy,
   output logic [NUM_PORTS*STAT_WIDTH-1:0]     stat_frames
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W      = clog2(NUM_PORTS);
   localparam int unsigned GAP_W      = 4;

   arb_state_t           r_state, w_state_nxt;
   logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]     r_idx, w_idx_nxt;
   logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
   logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;
   logic                 r_busy;
   logic [NUM_PORTS-1:0] w_req, w_win;
   logic [PTR_W-1:0]     w_win_idx;
   logic                 w_xfer, w_last_acc;

   assign w_req = s_axis_tvalid & port_enable;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_rr_arbiter (
      .req     (w_req),
      .ptr     (r_ptr),
      .win     (w_win),
      .win_idx (w_win_idx)
   );

   // Zero-latency pass-through of the owning port; everything is zero with no owner.
   assign w_xfer        = (r_state == ST_XFER);
   assign m_axis_tvalid = w_xfer & s_axis_tvalid[r_idx];
   assign m_axis_tlast  = w_xfer & s_axis_tlast[r_idx];
   assign m_axis_tdata  = w_xfer ? s_axis_tdata[32'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign m_axis_tkeep  = w_xfer ? s_axis_tkeep[32'(r_idx)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
   assign s_axis_tready = r_grant & {NUM_PORTS{m_axis_tready}};
   assign w_last_acc    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   assign grant = r_grant;
   assign busy  = r_busy;

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_idx_nxt     = r_idx;
      w_grant_nxt   = r_grant;
      w_gap_cnt_nxt = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            if (|w_req) begin
               w_state_nxt = ST_XFER;
               w_grant_nxt = w_win;
               w_idx_nxt   = w_win_idx;
               w_ptr_nxt   = w_win_idx;
            end
         end
         ST_XFER: begin
            if (w_last_acc) begin
               w_grant_nxt = '0;
               if (IDLE_GAP == 0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt   = ST_GAP;
                  w_gap_cnt_nxt = GAP_W'(IDLE_GAP - 1);
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= PTR_W'(NUM_PORTS - 1);
         r_idx     <= '0;
         r_grant   <= '0;
         r_gap_cnt <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_idx     <= w_idx_nxt;
         r_grant   <= w_grant_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

`ifdef ARB_STATS_EN
   logic [STAT_WIDTH-1:0] r_stat [NUM_PORTS];

   // Counts accepted end-of-frame beats per owner; wraps naturally.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) r_stat[p] <= '0;
      end else if (w_last_acc) begin
         r_stat[r_idx] <= r_stat[r_idx] + STAT_WIDTH'(1);
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
      assign stat_frames[g*STAT_WIDTH +: STAT_WIDTH] = r_stat[g];
   end
`else
   assign stat_frames = '0;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: arbitration table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_mac_tx_arbiter;

   localparam int NP  = 4;
   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int GAP = 1;
   localparam int SW  = 32;

   logic               sys_clk   = 1'b0;
   logic               sys_rst_n = 1'b1;
   logic [NP*DW-1:0]   s_axis_tdata;
   logic [NP*KW-1:0]   s_axis_tkeep;
   logic [NP-1:0]      s_axis_tvalid;
   logic [NP-1:0]      s_axis_tlast;
   logic [NP-1:0]      s_axis_tready;
   logic [DW-1:0]      m_axis_tdata;
   logic [KW-1:0]      m_axis_tkeep;
   logic               m_axis_tvalid;
   logic               m_axis_tlast;
   logic               m_axis_tready;
   logic [NP-1:0]      port_enable;
   logic [NP-1:0]      grant;
   logic               busy;
   logic [NP*SW-1:0]   stat_frames;

   mac_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IDLE_GAP(GAP), .STAT_WIDTH(SW)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .port_enable   (port_enable),
      .grant         (grant),
      .busy          (busy),
      .stat_frames   (stat_frames)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   typedef struct {
      logic [NP-1:0] valid;
      logic [NP-1:0] en;
      logic [NP-1:0] exp_grant;
   } vec_t;

   beat_t       src_mem [NP][256];
   int          src_rd [NP];
   int          src_wr [NP];
   logic [NP-1:0] gate;
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          chk_en    = 0;
   bit          rand_mode = 0;
   bit          sb_en     = 0;
   int          log_port[$];
   int          log_frame[$];
   logic [31:0] log_data[$];
   int          exp_seq [NP];
   int          push_seq [NP];
   int          sent [NP];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: owner/gap/last-winner tracked from the arbitration rules.
   int m_owner = -1;
   int m_gap   = 0;
   int m_last  = NP - 1;
`ifdef ARB_STATS_EN
   logic [SW-1:0] m_stat [NP] = '{default: '0};
`endif

   function automatic int pick(input logic [NP-1:0] req, input int last);
      for (int i = 1; i <= NP; i++)
         if (req[(last + i) % NP]) return (last + i) % NP;
      return -1;
   endfunction

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_owner <= -1;
         m_gap   <= 0;
         m_last  <= NP - 1;
`ifdef ARB_STATS_EN
         for (int p = 0; p < NP; p++) m_stat[p] <= '0;
`endif
      end else if (m_owner >= 0) begin
         if (s_axis_tvalid[m_owner] && m_axis_tready && s_axis_tlast[m_owner]) begin
            m_owner <= -1;
            m_gap   <= GAP;
`ifdef ARB_STATS_EN
            m_stat[m_owner] <= m_stat[m_owner] + 1;
`endif
         end
      end else if (m_gap > 0) begin
         m_gap <= m_gap - 1;
      end else if (pick(s_axis_tvalid & port_enable, m_last) >= 0) begin
         m_owner <= pick(s_axis_tvalid & port_enable, m_last);
         m_last  <= pick(s_axis_tvalid & port_enable, m_last);
      end
   end

   always @(negedge sys_clk) begin
      if (chk_en) begin
         check("grant", 64'(grant), (m_owner >= 0) ? 64'(1 << m_owner) : 64'd0);
         check("busy", 64'(busy), 64'(m_owner >= 0 || m_gap > 0));
         check("m_tvalid", 64'(m_axis_tvalid), (m_owner >= 0) ? 64'(s_axis_tvalid[m_owner]) : 64'd0);
         check("m_tlast", 64'(m_axis_tlast), (m_owner >= 0) ? 64'(s_axis_tlast[m_owner]) : 64'd0);
         check("m_tdata", 64'(m_axis_tdata), (m_owner >= 0) ? 64'(s_axis_tdata[m_owner*DW +: DW]) : 64'd0);
         check("m_tkeep", 64'(m_axis_tkeep), (m_owner >= 0) ? 64'(s_axis_tkeep[m_owner*KW +: KW]) : 64'd0);
         check("s_tready", 64'(s_axis_tready),
               (m_owner >= 0 && m_axis_tready) ? 64'(1 << m_owner) : 64'd0);
         for (int p = 0; p < NP; p++) begin
`ifdef ARB_STATS_EN
            check($sformatf("stat%0d", p), 64'(stat_frames[p*SW +: SW]), 64'(m_stat[p]));
`else
            check($sformatf("stat%0d", p), 64'(stat_frames[p*SW +: SW]), 64'd0);
`endif
         end
      end
   end

   task automatic drive();
      beat_t b;
      for (int p = 0; p < NP; p++) begin
         if (src_rd[p] < src_wr[p]) begin
            b = src_mem[p][src_rd[p]];
            s_axis_tvalid[p]           = gate[p];
            s_axis_tdata[p*DW +: DW]   = b.data;
            s_axis_tkeep[p*KW +: KW]   = b.keep;
            s_axis_tlast[p]            = b.last;
         end else begin
            s_axis_tvalid[p]           = 1'b0;
            s_axis_tdata[p*DW +: DW]   = '0;
            s_axis_tkeep[p*KW +: KW]   = '0;
            s_axis_tlast[p]            = 1'b0;
         end
      end
   endtask

   task automatic push_frame(input int p, input int n, input logic [31:0] base, input bit rkeep);
      for (int i = 0; i < n; i++) begin
         src_mem[p][src_wr[p]] = '{data: base + 32'(i), keep: rkeep ? 4'($urandom) : 4'hF,
                                   last: (i == n - 1)};
         src_wr[p]++;
      end
   endtask

   task automatic clear_src();
      for (int p = 0; p < NP; p++) begin
         src_rd[p] = 0;
         src_wr[p] = 0;
      end
   endtask

   task automatic clear_logs();
      log_port.delete();
      log_frame.delete();
      log_data.delete();
   endtask

   function automatic bit queues_empty();
      for (int p = 0; p < NP; p++) if (src_rd[p] != src_wr[p]) return 0;
      return 1;
   endfunction

   task automatic log_beat();
      int gp;
      gp = -1;
      for (int p = 0; p < NP; p++) if (grant[p]) gp = p;
      log_port.push_back(gp);
      log_data.push_back(m_axis_tdata);
      if (m_axis_tlast) log_frame.push_back(gp);
      if (sb_en && gp >= 0) begin
         check("sb_port", 64'(m_axis_tdata[31:24]), 64'(gp));
         check("sb_seq", 64'(m_axis_tdata[23:0]), 64'(exp_seq[gp]));
         exp_seq[gp]++;
      end
   endtask

   // One clock: sample handshakes away from the edge, then pop and re-drive after it.
   task automatic cycle();
      logic [NP-1:0] acc;
      @(negedge sys_clk);
      acc = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) log_beat();
      @(posedge sys_clk);
      #1;
      for (int p = 0; p < NP; p++) if (acc[p]) src_rd[p]++;
      if (rand_mode) begin
         for (int p = 0; p < NP; p++) gate[p] = ($urandom_range(0, 3) != 0);
         m_axis_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) port_enable[$urandom_range(0, NP - 1)] ^= 1'b1;
      end
      drive();
   endtask

   task automatic wait_idle(input int max, input string name);
      bit done;
      done = 0;
      for (int c = 0; c < max && !done; c++) begin
         cycle();
         if (queues_empty() && !busy && !m_axis_tvalid) done = 1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s: not idle after %0d cycles", name, max);
      end
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      clear_src();
      gate          = '1;
      port_enable   = '1;
      m_axis_tready = 1'b1;
      drive();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      clear_logs();
   endtask

   vec_t tbl [11];
   int   exp2 [6] = '{0, 0, 0, 2, 2, 2};
   int   t5_bad;
   bit   found;

   initial begin
      // Rows chain from the reset pointer; each row's winner becomes the next pointer.
      tbl[0]  = '{4'b0101, 4'b1111, 4'b0001};
      tbl[1]  = '{4'b0101, 4'b1111, 4'b0100};
      tbl[2]  = '{4'b0101, 4'b1111, 4'b0001};
      tbl[3]  = '{4'b1111, 4'b1101, 4'b0100};
      tbl[4]  = '{4'b1111, 4'b1111, 4'b1000};
      tbl[5]  = '{4'b0010, 4'b1111, 4'b0010};
      tbl[6]  = '{4'b0010, 4'b1111, 4'b0010};
      tbl[7]  = '{4'b1001, 4'b0001, 4'b0001};
      tbl[8]  = '{4'b1110, 4'b1111, 4'b0010};
      tbl[9]  = '{4'b1000, 4'b1000, 4'b1000};
      tbl[10] = '{4'b0111, 4'b0111, 4'b0001};

      for (int p = 0; p < NP; p++) begin
         exp_seq[p] = 0; push_seq[p] = 0; sent[p] = 0;
      end
      clear_src();
      gate          = '1;
      port_enable   = '1;
      m_axis_tready = 1'b1;
      drive();
      #1 sys_rst_n = 1'b0;
      #20;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      chk_en    = 1;

      // Idle after reset.
      repeat (20) cycle();
      check("t1_grant", 64'(grant), 64'd0);
      check("t1_busy", 64'(busy), 64'd0);
      check("t1_m_tvalid", 64'(m_axis_tvalid), 64'd0);

      // Arbitration table with single-beat frames.
      for (int r = 0; r < 11; r++) begin
         clear_src();
         port_enable = tbl[r].en;
         for (int p = 0; p < NP; p++)
            if (tbl[r].valid[p]) push_frame(p, 1, 32'hA000_0000 + 32'(r * 16 + p), 0);
         drive();
         found = 0;
         for (int c = 0; c < 10 && !found; c++) begin
            cycle();
            if (grant != '0) found = 1;
         end
         check($sformatf("tbl%0d_grant", r), 64'(grant), 64'(tbl[r].exp_grant));
         cycle();
         clear_src();
         drive();
         repeat (3) cycle();
      end

      // Ports 0 and 2 simultaneous 3-beat frames.
      do_reset();
      push_frame(0, 3, 32'h0000_0A00, 0);
      push_frame(2, 3, 32'h0000_0C00, 0);
      drive();
      wait_idle(50, "t2_drain");
      check("t2_nbeats", 64'(log_port.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < log_port.size()) check($sformatf("t2_beat%0d_port", i), 64'(log_port[i]), 64'(exp2[i]));

      // All ports saturated: frames rotate 0,1,2,3,0,1,2,3.
      do_reset();
      for (int f = 0; f < 2; f++)
         for (int p = 0; p < NP; p++) push_frame(p, 4, 32'(p * 256 + f * 16), 1);
      drive();
      wait_idle(200, "t3_drain");
      check("t3_nframes", 64'(log_frame.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         if (i < log_frame.size()) check($sformatf("t3_frame%0d_port", i), 64'(log_frame[i]), 64'(i % NP));

      // MAC back-pressure toggling during a 5-beat frame on port 1.
      do_reset();
      push_frame(1, 5, 32'h1111_0001, 0);
      drive();
      for (int c = 0; c < 60 && log_frame.size() == 0; c++) begin
         cycle();
         m_axis_tready = ~m_axis_tready;
         #1;
         if (grant[1]) check("t4_tready_mirror", 64'(s_axis_tready[1]), 64'(m_axis_tready));
      end
      m_axis_tready = 1'b1;
      wait_idle(20, "t4_drain");
      check("t4_nbeats", 64'(log_data.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         if (i < log_data.size()) check($sformatf("t4_data%0d", i), 64'(log_data[i]), 64'(32'h1111_0001 + i));

      // Port 1 disabled mid-frame while port 3 waits.
      do_reset();
      push_frame(1, 4, 32'h0000_1100, 0);
      drive();
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         cycle();
         if (grant[1]) found = 1;
      end
      if (!found) begin
         n_checks++;
         $display("FAIL t5_first_grant: port 1 never granted");
      end
      push_frame(3, 2, 32'h0000_3300, 0);
      push_frame(1, 2, 32'h0000_1200, 0);
      port_enable[1] = 1'b0;
      drive();
      t5_bad = 0;
      for (int c = 0; c < 30; c++) begin
         cycle();
         if (log_frame.size() >= 1 && grant[1]) t5_bad++;
      end
      check("t5_no_regrant", 64'(t5_bad), 64'd0);
      check("t5_nframes", 64'(log_frame.size()), 64'd2);
      if (log_frame.size() >= 2) begin
         check("t5_first", 64'(log_frame[0]), 64'd1);
         check("t5_second", 64'(log_frame[1]), 64'd3);
      end
      port_enable[1] = 1'b1;
      drive();
      wait_idle(50, "t5_drain");
      check("t5_nframes_final", 64'(log_frame.size()), 64'd3);

      // Reset pulse in the middle of a frame.
      do_reset();
      push_frame(0, 4, 32'h0000_0600, 0);
      drive();
      for (int c = 0; c < 20 && log_port.size() < 2; c++) cycle();
      #2 sys_rst_n = 1'b0;
      #1;
      check("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t6_m_tdata", 64'(m_axis_tdata), 64'd0);
      check("t6_grant", 64'(grant), 64'd0);
      check("t6_s_tready", 64'(s_axis_tready), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      clear_src();
      drive();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      check("t6_stats_cleared", 64'(|stat_frames), 64'd0);
      clear_logs();
      push_frame(2, 1, 32'h0000_0620, 0);
      push_frame(0, 1, 32'h0000_0600, 0);
      drive();
      wait_idle(30, "t6_drain");
      check("t6_nframes", 64'(log_frame.size()), 64'd2);
      if (log_frame.size() >= 1) check("t6_first_winner", 64'(log_frame[0]), 64'd0);

      // Randomized traffic with frame-integrity scoreboard.
      do_reset();
      sb_en     = 1;
      rand_mode = 1;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            int p;
            int n;
            p = $urandom_range(0, NP - 1);
            n = $urandom_range(1, 4);
            if (src_wr[p] - src_rd[p] < 8 && src_wr[p] < 240) begin
               push_frame(p, n, {8'(p), 24'(push_seq[p])}, 1);
               for (int i = 0; i < n; i++) src_mem[p][src_wr[p] - n + i].data = {8'(p), 24'(push_seq[p] + i)};
               push_seq[p] += n;
               sent[p]++;
            end
         end
         cycle();
      end
      rand_mode     = 0;
      gate          = '1;
      port_enable   = '1;
      m_axis_tready = 1'b1;
      drive();
      wait_idle(600, "rand_drain");
      for (int p = 0; p < NP; p++) begin
         int cnt;
         cnt = 0;
         foreach (log_frame[i]) if (log_frame[i] == p) cnt++;
         check($sformatf("rand_frames_p%0d", p), 64'(cnt), 64'(sent[p]));
         check($sformatf("rand_beats_p%0d", p), 64'(exp_seq[p]), 64'(push_seq[p]));
      end
      sb_en  = 0;
      chk_en = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
